// File: rtl/cvt_int2fp_cmp_fp2int_pkg.sv
// Shared widths, fp field types and the fp->int helper for the int2fp/fp2int round-trip path.
// Select fp32 by setting WORD_LEN/FP_EXP_WIDTH/FP_MANT_WIDTH to 32/8/23.
package cvt_params_pkg;

  localparam int unsigned WORD_LEN      = 16;
  localparam int unsigned FP_EXP_WIDTH  = 5;
  localparam int unsigned FP_MANT_WIDTH = 10;
  localparam int unsigned FP_BIAS       = (1 << (FP_EXP_WIDTH - 1)) - 1;
  localparam int unsigned F2I_W         = WORD_LEN + FP_MANT_WIDTH + 1;

  typedef logic [WORD_LEN-1:0]      word_t;
  typedef logic [FP_EXP_WIDTH-1:0]  fp_exp_t;
  typedef logic [FP_MANT_WIDTH-1:0] fp_mant_t;

  typedef struct packed {
    logic  valid;
    word_t value;
  } int_res_t;

  // Truncating fp->int with signed saturation; exponents far above the word range clamp early.
  function automatic int_res_t fp2int(input logic f_sign, input fp_exp_t f_exp, input fp_mant_t f_mant);
    int_res_t         r;
    int               e;
    logic [F2I_W-1:0] big;
    logic [F2I_W-1:0] lim;
    r.valid = (f_exp != '1);
    r.value = '0;
    big     = '0;
    e       = int'(f_exp) - int'(FP_BIAS);
    lim     = f_sign ? (F2I_W'(1) << (WORD_LEN - 1))
                     : ((F2I_W'(1) << (WORD_LEN - 1)) - F2I_W'(1));
    if (r.valid && (f_exp != '0) && (e >= 0)) begin
      if (e > int'(WORD_LEN)) big = '1;
      else                    big = (F2I_W'({1'b1, f_mant}) << e) >> FP_MANT_WIDTH;
      if (big > lim) big = lim;
      r.value = f_sign ? -big[WORD_LEN-1:0] : big[WORD_LEN-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/cvt_int2fp_cmp_fp2int_reduce.sv
// Signed max/min reduction tree over valid-qualified words; ties resolve to the lowest index.
module cvt_cmp_reduce #(
  parameter int unsigned NUM_WORDS = 8,
  parameter int unsigned WIDTH     = 16
) (
  input  logic                            i_max,
  input  logic [NUM_WORDS-1:0]            i_valid,
  input  logic [NUM_WORDS-1:0][WIDTH-1:0] i_value,
  output logic                            o_any_valid,
  output logic [WIDTH-1:0]                o_value
);

  localparam int unsigned LVLS = $clog2(NUM_WORDS);
  localparam int unsigned P    = 1 << LVLS;

  logic [P-1:0][WIDTH-1:0] w_pad_val;
  logic [P-1:0]            w_pad_vld;
  logic [WIDTH-1:0]        w_val [LVLS+1][P];
  logic                    w_vld [LVLS+1][P];

  always_comb begin
    w_pad_val                  = '0;
    w_pad_vld                  = '0;
    w_pad_val[NUM_WORDS-1:0]   = i_value;
    w_pad_vld[NUM_WORDS-1:0]   = i_valid;
    for (int unsigned l = 0; l <= LVLS; l++) begin
      for (int unsigned n = 0; n < P; n++) begin
        w_val[l][n] = '0;
        w_vld[l][n] = 1'b0;
      end
    end
    for (int unsigned n = 0; n < P; n++) begin
      w_val[0][n] = w_pad_val[n];
      w_vld[0][n] = w_pad_vld[n];
    end
    // Left operand always covers lower indices, so it wins on equality.
    for (int unsigned l = 0; l < LVLS; l++) begin
      for (int unsigned n = 0; n < (P >> (l + 1)); n++) begin
        if (w_vld[l][2*n+1] &&
            (!w_vld[l][2*n] ||
             (i_max ? ($signed(w_val[l][2*n+1]) > $signed(w_val[l][2*n]))
                    : ($signed(w_val[l][2*n+1]) < $signed(w_val[l][2*n]))))) begin
          w_val[l+1][n] = w_val[l][2*n+1];
          w_vld[l+1][n] = 1'b1;
        end else begin
          w_val[l+1][n] = w_val[l][2*n];
          w_vld[l+1][n] = w_vld[l][2*n];
        end
      end
    end
  end

  assign o_any_valid = w_vld[LVLS][0];
  assign o_value     = w_vld[LVLS][0] ? w_val[LVLS][0] : '0;

endmodule

// File: rtl/cvt_int2fp_cmp_fp2int.sv
// Two-stage int->fp->int round trip with max/min of the back-converted words.
// Define CVT_ROUND_NEAREST_EN for round-to-nearest-even in stage 1 (default truncates).
module cvt_int2fp_cmp_fp2int
  import cvt_params_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 8
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    cmp_type_i,
  input  logic [NUM_WORDS-1:0][WORD_LEN-1:0]      int_i,
  output logic [NUM_WORDS-1:0]                    fp_sign_o,
  output logic [NUM_WORDS-1:0][FP_EXP_WIDTH-1:0]  fp_exp_o,
  output logic [NUM_WORDS-1:0][FP_MANT_WIDTH-1:0] fp_mant_o,
  output logic [NUM_WORDS-1:0]                    int_valid_o,
  output logic [NUM_WORDS-1:0][WORD_LEN-1:0]      int_full_o,
  output logic                                    comp_int_en_o,
  output logic [WORD_LEN-1:0]                     comp_int_o
);

  localparam int unsigned PW     = $clog2(WORD_LEN);
  localparam int unsigned NORM_W = WORD_LEN + FP_MANT_WIDTH;

  logic [NUM_WORDS-1:0]                    w_sign,  r_fp_sign;
  logic [NUM_WORDS-1:0][FP_EXP_WIDTH-1:0]  w_exp,   r_fp_exp;
  logic [NUM_WORDS-1:0][FP_MANT_WIDTH-1:0] w_mant,  r_fp_mant;
  logic [NUM_WORDS-1:0]                    w_int_valid, r_int_valid;
  logic [NUM_WORDS-1:0][WORD_LEN-1:0]      w_int_full,  r_int_full;
  logic                                    w_any, r_comp_en;
  logic [WORD_LEN-1:0]                     w_comp, r_comp_int;

  always_comb begin : s1_int2fp
    logic [WORD_LEN-1:0] w_mag;
    logic [PW-1:0]       w_p;
    logic [NORM_W-1:0]   w_norm;
    fp_exp_t             w_e;
    fp_mant_t            w_m;
`ifdef CVT_ROUND_NEAREST_EN
    logic                w_carry;
    fp_mant_t            w_m_inc;
    w_carry = 1'b0;
    w_m_inc = '0;
`endif
    w_mag  = '0;
    w_p    = '0;
    w_norm = '0;
    w_e    = '0;
    w_m    = '0;
    w_sign = '0;
    w_exp  = '0;
    w_mant = '0;
    for (int unsigned i = 0; i < NUM_WORDS; i++) begin
      w_mag = int_i[i][WORD_LEN-1] ? -int_i[i] : int_i[i];
      w_p   = '0;
      for (int unsigned b = 0; b < WORD_LEN; b++)
        if (w_mag[b]) w_p = PW'(b);
      // Normalise the leading one to the top bit; the mantissa sits directly beneath it.
      w_norm = {w_mag, {FP_MANT_WIDTH{1'b0}}} << (PW'(WORD_LEN - 1) - w_p);
      w_e    = fp_exp_t'(w_p) + fp_exp_t'(FP_BIAS);
      w_m    = fp_mant_t'(w_norm >> (WORD_LEN - 1));
`ifdef CVT_ROUND_NEAREST_EN
      if (w_norm[WORD_LEN-2] && ((|w_norm[WORD_LEN-3:0]) || w_m[0])) begin
        {w_carry, w_m_inc} = {1'b0, w_m} + {{FP_MANT_WIDTH{1'b0}}, 1'b1};
        w_m = w_m_inc;
        if (w_carry) w_e = w_e + fp_exp_t'(1);
      end
`endif
      if (w_mag != '0) begin
        w_sign[i] = int_i[i][WORD_LEN-1];
        w_exp[i]  = w_e;
        w_mant[i] = w_m;
      end
    end
  end

  always_comb begin : s2_fp2int
    int_res_t w_res;
    w_res       = '0;
    w_int_valid = '0;
    w_int_full  = '0;
    for (int unsigned i = 0; i < NUM_WORDS; i++) begin
      w_res          = fp2int(r_fp_sign[i], r_fp_exp[i], r_fp_mant[i]);
      w_int_valid[i] = w_res.valid;
      w_int_full[i]  = w_res.value;
    end
  end

  cvt_cmp_reduce #(
    .NUM_WORDS (NUM_WORDS),
    .WIDTH     (WORD_LEN)
  ) u_reduce (
    .i_max       (cmp_type_i),
    .i_valid     (w_int_valid),
    .i_value     (w_int_full),
    .o_any_valid (w_any),
    .o_value     (w_comp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fp_sign   <= '0;
      r_fp_exp    <= '0;
      r_fp_mant   <= '0;
      r_int_valid <= '0;
      r_int_full  <= '0;
      r_comp_en   <= 1'b0;
      r_comp_int  <= '0;
    end else begin
      r_fp_sign   <= w_sign;
      r_fp_exp    <= w_exp;
      r_fp_mant   <= w_mant;
      r_int_valid <= w_int_valid;
      r_int_full  <= w_int_full;
      r_comp_en   <= w_any;
      r_comp_int  <= w_comp;
    end
  end

  assign fp_sign_o     = r_fp_sign;
  assign fp_exp_o      = r_fp_exp;
  assign fp_mant_o     = r_fp_mant;
  assign int_valid_o   = r_int_valid;
  assign int_full_o    = r_int_full;
  assign comp_int_en_o = r_comp_en;
  assign comp_int_o    = r_comp_int;

endmodule

// File: tb/tb_cvt_int2fp_cmp_fp2int.sv
// Bench for cvt_int2fp_cmp_fp2int: arithmetic reference model of the two-stage pipeline.
module tb_cvt_int2fp_cmp_fp2int;
  import cvt_params_pkg::*;

  localparam int unsigned NW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic cmp_type_i = 1'b0;
  logic [NW-1:0][WORD_LEN-1:0]      int_i = '0;
  logic [NW-1:0]                    fp_sign_o;
  logic [NW-1:0][FP_EXP_WIDTH-1:0]  fp_exp_o;
  logic [NW-1:0][FP_MANT_WIDTH-1:0] fp_mant_o;
  logic [NW-1:0]                    int_valid_o;
  logic [NW-1:0][WORD_LEN-1:0]      int_full_o;
  logic                             comp_int_en_o;
  logic [WORD_LEN-1:0]              comp_int_o;

  int errors = 0;
  int checks = 0;

  int m_sign [NW];
  int m_exp  [NW];
  int m_mant [NW];
  logic [NW-1:0]                    e_sign, e_valid;
  logic [NW-1:0][FP_EXP_WIDTH-1:0]  e_exp;
  logic [NW-1:0][FP_MANT_WIDTH-1:0] e_mant;
  logic [NW-1:0][WORD_LEN-1:0]      e_full;
  logic                             e_en;
  logic [WORD_LEN-1:0]              e_comp;
  logic [NW-1:0][FP_EXP_WIDTH-1:0]  f_exp;

  always #5 clk = ~clk;

  cvt_int2fp_cmp_fp2int #(.NUM_WORDS(NW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmp_type_i    (cmp_type_i),
    .int_i         (int_i),
    .fp_sign_o     (fp_sign_o),
    .fp_exp_o      (fp_exp_o),
    .fp_mant_o     (fp_mant_o),
    .int_valid_o   (int_valid_o),
    .int_full_o    (int_full_o),
    .comp_int_en_o (comp_int_en_o),
    .comp_int_o    (comp_int_o)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // value = sign * floor(|x|) quantised to MANT bits below the leading one
  function automatic void ref_i2f(input int x, output int s, output int e, output int m);
    longint mag, pw, q, rem;
    int p;
    s = (x < 0) ? 1 : 0;
    mag = (x < 0) ? -longint'(x) : longint'(x);
    e = 0; m = 0;
    if (mag == 0) begin s = 0; return; end
    p = 0;
    while ((longint'(1) << (p + 1)) <= mag) p++;
    pw  = longint'(1) << p;
    q   = ((mag - pw) << FP_MANT_WIDTH) / pw;
    rem = ((mag - pw) << FP_MANT_WIDTH) % pw;
`ifdef CVT_ROUND_NEAREST_EN
    if ((2 * rem > pw) || ((2 * rem == pw) && (q % 2 == 1))) q++;
    if (q == (longint'(1) << FP_MANT_WIDTH)) begin q = 0; p++; end
`endif
    e = p + int'(FP_BIAS);
    m = int'(q);
  endfunction

  function automatic void ref_f2i(input int s, input int e, input int m, output int v, output longint r);
    longint mag, lim;
    int sh;
    v = 1; r = 0;
    if (e == (1 << FP_EXP_WIDTH) - 1) begin v = 0; return; end
    if (e == 0) return;
    sh  = e - int'(FP_BIAS) - int'(FP_MANT_WIDTH);
    mag = (longint'(1) << FP_MANT_WIDTH) + longint'(m);
    if (sh >= 0) mag = (sh > 40) ? (longint'(1) << 50) : (mag << sh);
    else         mag = (-sh > 40) ? 0 : (mag >> (-sh));
    lim = longint'(1) << (WORD_LEN - 1);
    if (s != 0) r = (mag >= lim) ? -lim : -mag;
    else        r = (mag > lim - 1) ? lim - 1 : mag;
  endfunction

  task automatic compute_s2();
    int best, v;
    longint bv, r;
    best = -1; bv = 0;
    for (int i = 0; i < NW; i++) begin
      ref_f2i(m_sign[i], m_exp[i], m_mant[i], v, r);
      e_valid[i] = (v != 0);
      e_full[i]  = word_t'(r);
      if (v != 0 && (best < 0 || (cmp_type_i ? (r > bv) : (r < bv)))) begin
        best = i; bv = r;
      end
    end
    e_en   = (best >= 0);
    e_comp = (best >= 0) ? word_t'(bv) : '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NW; i++) begin m_sign[i] = 0; m_exp[i] = 0; m_mant[i] = 0; end
    e_sign = '0; e_exp = '0; e_mant = '0; e_valid = '0; e_full = '0; e_en = 1'b0; e_comp = '0;
  endtask

  task automatic model_edge();
    compute_s2();
    for (int i = 0; i < NW; i++) begin
      ref_i2f(int'($signed(int_i[i])), m_sign[i], m_exp[i], m_mant[i]);
      e_sign[i] = (m_sign[i] != 0);
      e_exp[i]  = fp_exp_t'(m_exp[i]);
      e_mant[i] = fp_mant_t'(m_mant[i]);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".fp_sign"},   256'(fp_sign_o),   256'(e_sign));
    chk({tag, ".fp_exp"},    256'(fp_exp_o),    256'(e_exp));
    chk({tag, ".fp_mant"},   256'(fp_mant_o),   256'(e_mant));
    chk({tag, ".int_valid"}, 256'(int_valid_o), 256'(e_valid));
    chk({tag, ".int_full"},  256'(int_full_o),  256'(e_full));
    chk({tag, ".comp"},      256'({comp_int_en_o, comp_int_o}), 256'({e_en, e_comp}));
  endtask

  task automatic tick(input bit do_check, input string tag);
    @(posedge clk);
    model_edge();
    #1;
    if (do_check) check_outputs(tag);
  endtask

  function automatic word_t rnd_word();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return word_t'(1) << (WORD_LEN - 1);
      2:       return ~(word_t'(1) << (WORD_LEN - 1));
      3:       return word_t'($urandom_range(0, 4200)) - word_t'(2100);
      default: return word_t'($urandom);
    endcase
  endfunction

  initial begin : main
    int v_tbl [NW] = '{1, -1, 1000, 0, -32768, 5, 2049, 32767};
    logic [15:0] fp_tbl [NW] = '{16'h3C00, 16'hBC00, 16'h63D0, 16'h0000,
                                 16'hF800, 16'h4500, 16'h6800, 16'h77FF};
    int back_tbl [NW] = '{1, -1, 1000, 0, -32768, 5, 2048, 32752};
    int v2_tbl [NW] = '{100, -200, 30000, 7, -5, 0, 1234, -32768};
    logic [NW-1:0][15:0]         obs_fp, exp_fp;
    logic [NW-1:0][WORD_LEN-1:0] exp_back;
    word_t                       max_exp;
`ifdef CVT_ROUND_NEAREST_EN
    int r_tbl [NW]  = '{2049, 2051, 2050, 32767, -2049, -2051, 3, -1};
    int rb_tbl [NW] = '{2048, 2052, 2050, 32767, -2048, -2052, 3, -1};
    fp_tbl[7]   = 16'h7800;
    back_tbl[7] = 32767;
    max_exp     = 16'd32767;
`else
    max_exp     = 16'd32752;
`endif

    // Power-on reset
    #1 rst_n = 1'b0;
    model_reset();
    #2 check_outputs("reset");
    #10 rst_n = 1'b1;
    tick(1, "first_capture");
    chk("first_capture.en_zero", 256'({comp_int_en_o, comp_int_o}), 256'({1'b1, 16'h0000}));

    // Directed vector, max then min
    for (int i = 0; i < NW; i++) int_i[i] = word_t'(v_tbl[i]);
    cmp_type_i = 1'b1;
    tick(1, "dir_s1");
    for (int i = 0; i < NW; i++) begin
      obs_fp[i] = {fp_sign_o[i], fp_exp_o[i], fp_mant_o[i]};
      exp_fp[i] = fp_tbl[i];
    end
    chk("dir.fp_hex", 256'(obs_fp), 256'(exp_fp));
    tick(1, "dir_max");
    for (int i = 0; i < NW; i++) exp_back[i] = word_t'(back_tbl[i]);
    chk("dir.back_ints", 256'(int_full_o), 256'(exp_back));
    chk("dir.max", 256'({comp_int_en_o, comp_int_o}), 256'({1'b1, max_exp}));
    cmp_type_i = 1'b0;
    tick(1, "dir_min");
    chk("dir.min", 256'({comp_int_en_o, comp_int_o}), 256'({1'b1, 16'h8000}));

    // Back-to-back random vectors
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NW; i++) int_i[i] = rnd_word();
      cmp_type_i = 1'($urandom);
      tick(1, "rand");
    end

    // Reset asserted mid-stream
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 model_reset();
    check_outputs("midrst_async");
    @(posedge clk);
    #1 check_outputs("midrst_hold");
    #3 rst_n = 1'b1;
    for (int i = 0; i < NW; i++) int_i[i] = rnd_word();
    tick(1, "midrst_release");
    chk("midrst_release.en_zero", 256'({comp_int_en_o, comp_int_o}), 256'({1'b1, 16'h0000}));
    for (int c = 0; c < 50; c++) begin
      for (int i = 0; i < NW; i++) int_i[i] = rnd_word();
      cmp_type_i = 1'($urandom);
      tick(1, "rand2");
    end

    // Inf/NaN exponents excluded from the compare
    for (int i = 0; i < NW; i++) int_i[i] = word_t'(v2_tbl[i]);
    cmp_type_i = 1'b1;
    tick(1, "pre_force");
    tick(1, "pre_force2");
    force dut.r_fp_exp = '1;
    @(posedge clk);
    #1;
    chk("force_all.comp", 256'({comp_int_en_o, comp_int_o}), 256'({1'b0, 16'h0000}));
    chk("force_all.valid", 256'(int_valid_o), 256'(0));
    chk("force_all.full", 256'(int_full_o), 256'(0));
    f_exp = e_exp;
    f_exp[2] = '1;
    force dut.r_fp_exp = f_exp;
    @(posedge clk);
    #1;
    m_exp[2] = (1 << FP_EXP_WIDTH) - 1;
    compute_s2();
    chk("force_one.valid", 256'(int_valid_o), 256'(e_valid));
    chk("force_one.full", 256'(int_full_o), 256'(e_full));
    chk("force_one.comp", 256'({comp_int_en_o, comp_int_o}), 256'({e_en, e_comp}));
    chk("force_one.max", 256'({comp_int_en_o, comp_int_o}), 256'({1'b1, 16'd1234}));
    release dut.r_fp_exp;
    tick(0, "resync");
    for (int c = 0; c < 5; c++) begin
      cmp_type_i = 1'($urandom);
      tick(1, "post_force");
    end

`ifdef CVT_ROUND_NEAREST_EN
    for (int i = 0; i < NW; i++) int_i[i] = word_t'(r_tbl[i]);
    tick(1, "round_s1");
    chk("round.fp_32767", 256'({fp_sign_o[3], fp_exp_o[3], fp_mant_o[3]}), 256'(16'h7800));
    tick(1, "round_s2");
    for (int i = 0; i < NW; i++) exp_back[i] = word_t'(rb_tbl[i]);
    chk("round.back_ints", 256'(int_full_o), 256'(exp_back));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
